shuffle_block_framer: RTL and testbench

Byte-stream front/back end for the 64-bit Fisher-Yates shuffler. Packs eight input bytes into one 64-bit block, presents it and a stored key to the shuffler, launches it with a single-cycle `shuffle_en` pulse, and waits for `done`. It then serialises `shuffle_out` back into bytes. It sits directly upstream and downstream of the shuffler, so the protocol side only ever handles byte streams.

---
 rtl/shuffle_pkg.sv | 16 +
 rtl/shuffle_block_framer_if.sv | 27 ++
 rtl/byte_serializer.sv | 60 ++++++
 rtl/shuffle_block_framer.sv | 165 ++++++++++++++++
 tb/tb_shuffle_block_framer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shuffle_pkg.sv
// Shared types and sizes for the shuffle block framer: the control state
// enum and the block geometry (eight bytes per 64-bit block).
package shuffle_pkg;

  localparam int BLK_BYTES = 8;
  localparam int BLK_W     = 64;
  localparam int CNT_W     = $clog2(BLK_BYTES);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/shuffle_block_framer_if.sv
// Byte-stream bundle for the shuffle block framer: the input byte stream
// and the output byte stream, each with a valid/ready handshake.
interface shuffle_block_framer_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  // Protocol side: produces input bytes, consumes output bytes.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Framer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/byte_serializer.sv
// Loads a 64-bit block and emits it LSB byte first over a valid/ready
// handshake, flagging the eighth beat and pulsing when that beat is taken.
module byte_serializer
  import shuffle_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BLK_W-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             last_accepted
);

  logic [BLK_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             valid_q, valid_d;
  logic             fire;

  assign fire = valid_q && out_ready;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sh_d    = sh_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    if (load) begin
      sh_d    = load_data;
      beat_d  = '0;
      valid_d = 1'b1;
    end else if (fire) begin
      sh_d   = sh_q >> 8;
      beat_d = beat_q + 1'b1;
      if (beat_q == CNT_W'(BLK_BYTES - 1)) valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_data      = sh_q[7:0];
  assign out_last      = valid_q && (beat_q == CNT_W'(BLK_BYTES - 1));
  assign last_accepted = fire && out_last;

endmodule

// File: rtl/shuffle_block_framer.sv
// Byte-stream front/back end for the 64-bit Fisher-Yates shuffler.
// Optional BUSY watchdog enabled by defining SHUF_TIMEOUT_EN.
module shuffle_block_framer
  import shuffle_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE    = 8'h00,
  parameter int         TIMEOUT_CYC = 8192
) (
  input  logic                   mclk,
  input  logic                   rst_n,
  shuffle_block_framer_if.slave  bus,
  input  logic                   key_load,
  input  logic [BLK_W-1:0]       key_wr,
  input  logic                   mode,
  output logic                   shf_en,
  output logic                   shf_deshuffle,
  output logic [BLK_W-1:0]       shf_data,
  output logic [BLK_W-1:0]       shf_key,
  input  logic                   shf_done,
  input  logic [BLK_W-1:0]       shf_result,
  output logic [15:0]            blk_cnt,
  output logic                   err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic             desh_q, desh_d;
  logic             shf_en_q, shf_en_d;
  logic             in_ready_q, in_ready_d;
  logic [15:0]      blk_cnt_q, blk_cnt_d;
  logic             accept;
  logic             ser_load;
  logic             ser_last_accepted;

`ifdef SHUF_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // in_ready_q is only ever high in FILL, so it doubles as the FILL qualifier.
  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    key_d      = key_q;
    desh_d     = desh_q;
    shf_en_d   = 1'b0;
    in_ready_d = in_ready_q;
    blk_cnt_d  = blk_cnt_q;
    ser_load   = 1'b0;
`ifdef SHUF_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      FILL: begin
        if (key_load && byte_cnt_q == '0) key_d = key_wr;
        if (accept) begin
          data_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
          if (byte_cnt_q == '0) desh_d = mode;
          if (bus.in_last || byte_cnt_q == CNT_W'(BLK_BYTES - 1)) begin
            // Bytes after an early in_last are padded.
            for (int j = 0; j < BLK_BYTES; j++) begin
              if (j > int'(byte_cnt_q)) data_d[j*8 +: 8] = PAD_BYTE;
            end
            byte_cnt_d = '0;
            state_d    = LAUNCH;
            shf_en_d   = 1'b1;
            in_ready_d = 1'b0;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      LAUNCH: begin
        state_d = BUSY;
`ifdef SHUF_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      BUSY: begin
        // A done in the same cycle as the timeout limit takes priority.
        if (shf_done) begin
          ser_load  = 1'b1;
          blk_cnt_d = blk_cnt_q + 16'd1;
          state_d   = DRAIN;
        end
`ifdef SHUF_TIMEOUT_EN
        else if (tmo_q == TMO_LIMIT) begin
          err_d      = 1'b1;
          state_d    = FILL;
          in_ready_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      DRAIN: begin
        if (ser_last_accepted) begin
          state_d    = FILL;
          in_ready_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      byte_cnt_q <= '0;
      data_q     <= '0;
      key_q      <= '0;
      desh_q     <= 1'b0;
      shf_en_q   <= 1'b0;
      in_ready_q <= 1'b1;
      blk_cnt_q  <= '0;
`ifdef SHUF_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      key_q      <= key_d;
      desh_q     <= desh_d;
      shf_en_q   <= shf_en_d;
      in_ready_q <= in_ready_d;
      blk_cnt_q  <= blk_cnt_d;
`ifdef SHUF_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  byte_serializer u_ser (
    .clk           (mclk),
    .rst_n         (rst_n),
    .load          (ser_load),
    .load_data     (shf_result),
    .out_ready     (bus.out_ready),
    .out_valid     (bus.out_valid),
    .out_data      (bus.out_data),
    .out_last      (bus.out_last),
    .last_accepted (ser_last_accepted)
  );

  assign bus.in_ready  = in_ready_q;
  assign shf_en        = shf_en_q;
  assign shf_deshuffle = desh_q;
  assign shf_data      = data_q;
  assign shf_key       = key_q;
  assign blk_cnt       = blk_cnt_q;

endmodule

// File: tb/tb_shuffle_block_framer.sv
// Self-checking bench for shuffle_block_framer with a bit-reversing stub
// shuffler; the timeout scenario runs only when SHUF_TIMEOUT_EN is defined.
module tb_shuffle_block_framer;
  import shuffle_pkg::*;

  localparam logic [7:0] PAD      = 8'h5A;
  localparam int         TMO      = 100;
  localparam int         STUB_LAT = 20;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_load = 1'b0;
  logic [63:0] key_wr = '0;
  logic        mode = 1'b0;
  logic        shf_en, shf_deshuffle;
  logic [63:0] shf_data, shf_key;
  logic        shf_done = 1'b0;
  logic [63:0] shf_result = '0;
  logic [15:0] blk_cnt;
  logic        err;

  always #5 mclk = ~mclk;

  shuffle_block_framer_if sif ();

  shuffle_block_framer #(.PAD_BYTE(PAD), .TIMEOUT_CYC(TMO)) dut (
    .mclk          (mclk),
    .rst_n         (rst_n),
    .bus           (sif),
    .key_load      (key_load),
    .key_wr        (key_wr),
    .mode          (mode),
    .shf_en        (shf_en),
    .shf_deshuffle (shf_deshuffle),
    .shf_data      (shf_data),
    .shf_key       (shf_key),
    .shf_done      (shf_done),
    .shf_result    (shf_result),
    .blk_cnt       (blk_cnt),
    .err           (err)
  );

  function automatic logic [63:0] bitrev(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[63-i];
    return r;
  endfunction

  // Stub shuffler: answers with the bit-reversed block STUB_LAT cycles after shf_en.
  logic        stub_en = 1'b1;
  int          stub_cnt = 0;
  logic [63:0] stub_res = '0;
  always @(posedge mclk) begin
    shf_done <= 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        shf_done   <= 1'b1;
        shf_result <= stub_res;
      end
    end
    if (shf_en && stub_en) begin
      stub_cnt <= STUB_LAT;
      stub_res <= bitrev(shf_data);
    end
  end

  int en_high = 0;
  always @(posedge mclk) if (shf_en) en_high++;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model_key = '0;
  int          model_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Feeds n bytes (LSB-first from bytes_in); returns the block the shuffler should see.
  task automatic send_block(input int n, input logic m, input logic [63:0] bytes_in,
                            input logic key_b0, input logic [63:0] kval,
                            input logic spur_key, output logic [63:0] exp_blk);
    int en0;
    en0 = en_high;
    for (int i = 0; i < 8; i++) exp_blk[i*8 +: 8] = (i < n) ? bytes_in[i*8 +: 8] : PAD;
    for (int i = 0; i < n; i++) begin
      @(negedge mclk);
      check("in_ready_fill", sif.in_ready, 1'b1);
      sif.in_valid = 1'b1;
      sif.in_data  = bytes_in[i*8 +: 8];
      sif.in_last  = (i == n - 1);
      mode         = (i == 0) ? m : ~m;
      key_load     = (i == 0 && key_b0) || (i == 1 && spur_key);
      key_wr       = (i == 0) ? kval : {$urandom, $urandom};
    end
    if (key_b0) model_key = kval;
    @(negedge mclk);
    sif.in_valid = 1'b0;
    sif.in_last  = 1'b0;
    key_load     = 1'b0;
    check("launch_en",       shf_en, 1'b1);
    check("launch_data",     shf_data, exp_blk);
    check("launch_key",      shf_key, model_key);
    check("launch_mode",     shf_deshuffle, m);
    check("launch_in_ready", sif.in_ready, 1'b0);
    @(negedge mclk);
    check("en_single_pulse", shf_en, 1'b0);
    check("en_pulse_count",  en_high - en0, 1);
    check("busy_data_hold",  shf_data, exp_blk);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (shf_done) seen = 1'b1;
      else @(negedge mclk);
    end
    check("done_seen", seen, 1'b1);
    check("out_valid_before_done", sif.out_valid, 1'b0);
  endtask

  task automatic drain_block(input logic [63:0] exp_res, input bit rnd_ready);
    int got;
    got = 0;
    @(negedge mclk);
    check("out_valid_rise", sif.out_valid, 1'b1);
    for (int cyc = 0; cyc < 500 && got < 8; cyc++) begin
      check("in_ready_drain", sif.in_ready, 1'b0);
      sif.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sif.out_valid && sif.out_ready) begin
        check("out_byte", sif.out_data, exp_res[got*8 +: 8]);
        check("out_last", sif.out_last, (got == 7));
        got++;
      end
      @(negedge mclk);
    end
    sif.out_ready = 1'b0;
    model_cnt = (model_cnt + 1) % 65536;
    check("drain_beats",     got, 8);
    check("post_in_ready",   sif.in_ready, 1'b1);
    check("post_out_valid",  sif.out_valid, 1'b0);
    check("post_blk_cnt",    blk_cnt, model_cnt);
    check("post_err",        err, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  sif.in_ready, 1'b1);
    check({tag, "_shf_en"},    shf_en, 1'b0);
    check({tag, "_shf_data"},  shf_data, 64'h0);
    check({tag, "_shf_key"},   shf_key, 64'h0);
    check({tag, "_desh"},      shf_deshuffle, 1'b0);
    check({tag, "_out_valid"}, sif.out_valid, 1'b0);
    check({tag, "_out_data"},  sif.out_data, 8'h00);
    check({tag, "_out_last"},  sif.out_last, 1'b0);
    check({tag, "_blk_cnt"},   blk_cnt, 16'h0);
    check({tag, "_err"},       err, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] blk;
    logic [63:0] bytes;
    int          n;
    sif.in_valid  = 1'b0;
    sif.in_data   = 8'h00;
    sif.in_last   = 1'b0;
    sif.out_ready = 1'b0;

    #12;
    check_idle_outputs("reset");
    @(negedge mclk);
    rst_n = 1'b1;

    // Block 1: directed bytes 01..08, key loaded in a separate FILL cycle.
    @(negedge mclk);
    key_load = 1'b1;
    key_wr   = 64'h0123456789ABCDEF;
    @(negedge mclk);
    key_load  = 1'b0;
    model_key = 64'h0123456789ABCDEF;
    send_block(8, 1'b0, 64'h0807060504030201, 1'b0, '0, 1'b0, blk);
    check("blk1_const", blk, 64'h0807060504030201);
    wait_done();
    drain_block(bitrev(blk), 1'b0);

    // Block 2: short block AA BB, deshuffle, key_load mid-block must be ignored.
    send_block(2, 1'b1, 64'h000000000000BBAA, 1'b0, '0, 1'b1, blk);
    check("blk2_const", blk, 64'h5A5A5A5A5A5ABBAA);
    wait_done();
    drain_block(bitrev(blk), 1'b1);

    // Random blocks: random lengths, modes, key loads with byte 0, stalls.
    for (int b = 0; b < 4; b++) begin
      n     = $urandom_range(1, 8);
      bytes = {$urandom, $urandom};
      send_block(n, 1'($urandom_range(0, 1)), bytes, 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)), blk);
      wait_done();
      drain_block(bitrev(blk), 1'b1);
    end

`ifdef SHUF_TIMEOUT_EN
    // Timeout: done never arrives; err is seen the cycle after BUSY cycle TMO.
    begin
      int c;
      stub_en = 1'b0;
      send_block(8, 1'b0, {$urandom, $urandom}, 1'b0, '0, 1'b0, blk);
      c = 1;
      while (!err && c < 300) begin
        @(negedge mclk);
        c++;
      end
      check("tmo_err_cycle",  c, TMO + 1);
      check("tmo_in_ready",   sif.in_ready, 1'b1);
      check("tmo_blk_cnt",    blk_cnt, model_cnt);
      @(negedge mclk);
      check("tmo_err_pulse",  err, 1'b0);
      check("tmo_out_valid",  sif.out_valid, 1'b0);
      stub_en = 1'b1;
      send_block(3, 1'b1, {$urandom, $urandom}, 1'b0, '0, 1'b0, blk);
      wait_done();
      drain_block(bitrev(blk), 1'b1);
    end
`endif

    // Reset asserted in BUSY: asynchronous clear, late done must be ignored.
    send_block(8, 1'b1, {$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 1'b0, blk);
    repeat (5) @(negedge mclk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    model_key = '0;
    model_cnt = 0;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    repeat (STUB_LAT + 5) @(negedge mclk);
    check("stray_done_blk_cnt",   blk_cnt, 16'h0);
    check("stray_done_out_valid", sif.out_valid, 1'b0);
    check("stray_done_in_ready",  sif.in_ready, 1'b1);

    // Fresh block after reset with the key reloaded alongside byte 0.
    send_block(8, 1'b0, {$urandom, $urandom}, 1'b1, 64'hFEDCBA9876543210, 1'b0, blk);
    wait_done();
    drain_block(bitrev(blk), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
